// File: rtl/and8_serial_pkg.sv
// and8_serial shared types: FSM state encoding and default operand width.
// Imported by the bit-serial AND top and its gate slice.
package and8_serial_pkg;

   localparam int unsigned DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/and8_serial_and.sv
// Single-bit AND gate slice: the only logic gate the serial datapath uses.
module and8_serial_and (
   input  logic a_i,
   input  logic b_i,
   output logic y_o
);

   assign y_o = a_i & b_i;

endmodule

// File: rtl/and8_serial.sv
// Bit-serial F = A & B, one bit per clock, LSB first, start/busy/done handshake.
// Optional define AND8_SERIAL_ZERO_FLAG_EN adds a registered all-zero result flag.
module and8_serial
   import and8_serial_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] F,
   output logic             f_bit,
`ifdef AND8_SERIAL_ZERO_FLAG_EN
   output logic             zero,
`endif
   output logic             f_valid
);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   sa_q, sb_q, f_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               bit_w;
   logic               last_w;
   logic               accept_w;
   logic               shift_w;

   and8_serial_and u_slice (
      .a_i (sa_q[0]),
      .b_i (sb_q[0]),
      .y_o (bit_w)
   );

   assign shift_w  = (state_q == SHIFT);
   assign last_w   = (cnt_q == CNT_W'(WIDTH - 1));
   assign accept_w = start && ((state_q == IDLE) || (state_q == DONE));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = SHIFT;
         SHIFT:   if (last_w) state_d = DONE;
         DONE:    state_d = start ? SHIFT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy    = shift_w;
      done    = (state_q == DONE);
      f_valid = shift_w;
      f_bit   = shift_w & bit_w;
      F       = f_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sa_q  <= '0;
         sb_q  <= '0;
         f_q   <= '0;
         cnt_q <= '0;
      end else if (accept_w) begin
         sa_q  <= A;
         sb_q  <= B;
         f_q   <= '0;
         cnt_q <= '0;
      end else if (shift_w) begin
         sa_q  <= {1'b0, sa_q[WIDTH-1:1]};
         sb_q  <= {1'b0, sb_q[WIDTH-1:1]};
         f_q   <= {bit_w, f_q[WIDTH-1:1]};
         // Hold at the top count so the counter never wraps.
         cnt_q <= last_w ? cnt_q : cnt_q + CNT_W'(1);
      end
   end

`ifdef AND8_SERIAL_ZERO_FLAG_EN
   logic seen_q;
   logic zero_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seen_q <= 1'b0;
         zero_q <= 1'b0;
      end else if (accept_w) begin
         seen_q <= 1'b0;
         zero_q <= 1'b0;
      end else if (shift_w) begin
         seen_q <= seen_q | bit_w;
         if (last_w) zero_q <= ~(seen_q | bit_w);
      end
   end

   assign zero = zero_q;
`endif

endmodule

// File: tb/tb_and8_serial.sv
// Directed self-checking bench for and8_serial (WIDTH=8 and WIDTH=4 instances).
module tb_and8_serial;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, start4;
   logic [7:0] A, B, F;
   logic [3:0] A4, B4, F4;
   logic       busy, done, f_bit, f_valid;
   logic       busy4, done4, f_bit4, f_valid4;
`ifdef AND8_SERIAL_ZERO_FLAG_EN
   logic       zero, zero4;
`endif

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   and8_serial #(.WIDTH(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .A       (A),
      .B       (B),
      .busy    (busy),
      .done    (done),
      .F       (F),
      .f_bit   (f_bit),
`ifdef AND8_SERIAL_ZERO_FLAG_EN
      .zero    (zero),
`endif
      .f_valid (f_valid)
   );

   and8_serial #(.WIDTH(4)) dut4 (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start4),
      .A       (A4),
      .B       (B4),
      .busy    (busy4),
      .done    (done4),
      .F       (F4),
      .f_bit   (f_bit4),
`ifdef AND8_SERIAL_ZERO_FLAG_EN
      .zero    (zero4),
`endif
      .f_valid (f_valid4)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         step();
         n++;
      end
   endtask

   task automatic run8(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp, input string tag);
      int n;
      A = a; B = b; start = 1'b1;
      step();
      start = 1'b0;
      chk({tag, "_busy"}, busy, 1);
      wait_done(n);
      chk({tag, "_lat"}, n, 8);
      chk({tag, "_F"}, F, exp);
`ifdef AND8_SERIAL_ZERO_FLAG_EN
      chk({tag, "_zero"}, zero, (exp == 8'h00));
`endif
      step();
   endtask

   logic [7:0] fbits_exp;
   int n;

   initial begin
      rst_n = 1'b0; start = 1'b0; start4 = 1'b0;
      A = '0; B = '0; A4 = '0; B4 = '0;
      step(); step();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_F", F, 0);
      chk("rst_fvalid", f_valid, 0);
      chk("rst_fbit", f_bit, 0);
`ifdef AND8_SERIAL_ZERO_FLAG_EN
      chk("rst_zero", zero, 0);
`endif
      rst_n = 1'b1;
      step();

      // F0 & 3C = 30, serial bits LSB first 0,0,0,0,1,1,0,0
      fbits_exp = 8'h30;
      A = 8'hF0; B = 8'h3C; start = 1'b1;
      step();
      start = 1'b0;
      A = 8'h00; B = 8'h00;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t1_busy%0d", i), busy, 1);
         chk($sformatf("t1_fvalid%0d", i), f_valid, 1);
         chk($sformatf("t1_fbit%0d", i), f_bit, fbits_exp[i]);
         chk($sformatf("t1_done%0d", i), done, 0);
         step();
      end
      chk("t1_done", done, 1);
      chk("t1_busy_off", busy, 0);
      chk("t1_fvalid_off", f_valid, 0);
      chk("t1_F", F, 8'h30);
      step();
      chk("t1_done_pulse", done, 0);
      chk("t1_F_hold", F, 8'h30);
      chk("t1_idle", busy, 0);

      run8(8'hFF, 8'hFF, 8'hFF, "ff");
      run8(8'hAA, 8'h55, 8'h00, "aa55");

      // start held high: back-to-back every 9 clocks, A change mid-run ignored
      A = 8'h0F; B = 8'hFF; start = 1'b1;
      step();
      A = 8'h01;
      chk("b2b_busy", busy, 1);
      wait_done(n);
      chk("b2b_lat1", n, 8);
      chk("b2b_F1", F, 8'h0F);
      A = 8'h0F;
      step();
      chk("b2b_nobubble", busy, 1);
      chk("b2b_done_low", done, 0);
      wait_done(n);
      chk("b2b_period", n + 1, 9);
      chk("b2b_F2", F, 8'h0F);
      start = 1'b0;
      step();
      chk("b2b_idle", busy, 0);

      // reset after 4 shift edges discards the partial result
      A = 8'hFF; B = 8'hFF; start = 1'b1;
      step();
      start = 1'b0;
      step(); step(); step(); step();
      chk("mid_busy", busy, 1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_F", F, 0);
      chk("mid_rst_done", done, 0);
      step();
      chk("mid_stay_idle", busy, 0);
      run8(8'h81, 8'h81, 8'h81, "x81");

      // start asserted in DONE
      A = 8'hFF; B = 8'h01; start = 1'b1;
      step();
      start = 1'b0;
      wait_done(n);
      chk("dn_F1", F, 8'h01);
      A = 8'h3C; B = 8'h0F; start = 1'b1;
      step();
      start = 1'b0;
      chk("dn_busy", busy, 1);
      chk("dn_notdone", done, 0);
      chk("dn_F_clr", F, 0);
      wait_done(n);
      chk("dn_lat", n, 8);
      chk("dn_F2", F, 8'h0C);
`ifdef AND8_SERIAL_ZERO_FLAG_EN
      chk("dn_zero", zero, 0);
`endif
      step();

      // WIDTH=4 instance: C & A = 8 after 4 clocks
      A4 = 4'hC; B4 = 4'hA; start4 = 1'b1;
      step();
      start4 = 1'b0;
      n = 0;
      while (done4 !== 1'b1 && n < 20) begin
         chk($sformatf("w4_busy%0d", n), busy4, 1);
         step();
         n++;
      end
      chk("w4_lat", n, 4);
      chk("w4_F", F4, 4'h8);
      chk("w4_busy_off", busy4, 0);
      step();
      chk("w4_done_pulse", done4, 0);
      chk("w4_F_hold", F4, 4'h8);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/and8_serial.md
Name: and8_serial

Overview:
Bit-serial counterpart to the parallel 8-bit AND: computes F = A & B one bit per clock through a single AND gate slice, under a start/busy/done handshake. Targets area-minimal datapaths where operands arrive as words but only one gate slice is affordable. Also streams each result bit as it is produced, for serial consumers.

Parameters:
WIDTH, 8, operand/result width in bits; must be >= 2
CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden

Ports:
clk      input   1      rising-edge clock
rst_n    input   1      synchronous active-low reset, sampled on rising edge of clk
start    input   1      request; sampled only in IDLE or DONE
A        input   WIDTH  operand A; captured on accepted start
B        input   WIDTH  operand B; captured on accepted start
busy     output  1      high while in SHIFT
done     output  1      one-cycle pulse; F valid
F        output  WIDTH  result register; holds until next accepted start
f_bit    output  1      current serial result bit, LSB first
f_valid  output  1      high in each cycle f_bit carries a result bit

Behaviour:
- Reset (rst_n low at an edge): state=IDLE, F=0, busy=0, done=0, f_bit=0, f_valid=0, operand shift regs=0, counter=0. Overrides every other input, including mid-SHIFT; the partial result is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 at edge E0 -> load sa<=A, sb<=B, cnt<=0, F<=0, state<=SHIFT. start=0 -> remain in IDLE.
- SHIFT (busy=1): every edge computes bit = sa[0] & sb[0] via the AND slice.
  - F <= {bit, F[WIDTH-1:1]}; sa, sb shift right by 1 with zero fill; cnt<=cnt+1.
  - During the cycle before that edge, f_bit = sa[0] & sb[0] and f_valid = 1.
  - On the edge where cnt==WIDTH-1, state<=DONE.
- Timing for WIDTH=8: bits consumed at E1..E8; DONE entered at E8; done=1 in the cycle after E8; latency is 8 clocks from the start-sampling edge to done. f_valid is high for exactly WIDTH cycles (E0..E8 interval).
- Handshake:
  - start while busy is ignored; operands are not re-sampled.
  - DONE lasts one cycle, then returns to IDLE, unless start=1 in DONE. That start is accepted exactly as in IDLE, giving back-to-back operation with no idle bubble.
  - done is never high together with busy.
- F output:
  - F holds its final value after DONE until the next accepted start, which clears it to 0.
  - Mid-operation F is partial; it is only guaranteed valid while done=1 and afterwards.
- Operands A and B may change freely after the accepting edge.
- The counter never wraps within a transaction; it is reset on every accept.

Optional Feature:
AND8_SERIAL_ZERO_FLAG_EN
- Defined: adds output port zero (1 bit, reset 0). zero is computed as "no 1 bit seen" during SHIFT and registered alongside done. zero=1 iff the final F==0. zero holds its value with F until the next accept, which clears it.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package and8_serial_pkg: state enum (IDLE, SHIFT, DONE) and a default-width constant of 8.
- One sub-module is natural: instantiate the existing single-bit AND gate as the bit slice. No other hierarchy.

Test Plan:
- Reset, then A=8'hF0, B=8'h3C, start pulse -> busy for 8 cycles, done 8 clocks after the start edge, F=8'h30. f_bit sequence, LSB first: 0,0,0,0,1,1,0,0.
- A=8'hFF, B=8'hFF -> F=8'hFF. Then A=8'hAA, B=8'h55 -> F=8'h00, zero=1 when AND8_SERIAL_ZERO_FLAG_EN is defined.
- start held high continuously with A=8'h0F, B=8'hFF -> done every 9 cycles with F=8'h0F. A change to A=8'h01 during busy has no effect on the current result.
- rst_n low for 1 cycle after 4 SHIFT edges -> next cycle busy=0, F=0, state IDLE. A fresh start with A=8'h81, B=8'h81 -> F=8'h81.
- start asserted in DONE with A=8'h3C, B=8'h0F -> no IDLE cycle, busy rises immediately, next F=8'h0C.
- WIDTH=4 instance, A=4'hC, B=4'hA -> done 4 clocks after start, F=4'h8.
